// File: rtl/hit_knockback.sv
// hit_knockback
// Player-1 (Ryu) attack sequencer and hit resolution against Akuma.
// A rising press of PUNCH_KEY starts an attack. The attack runs through
// STARTUP, ACTIVE and RECOVERY frames. While the hitbox is live, reach is
// tested against Akuma's position. A hit costs Akuma health and starts a
// per-frame horizontal knockback impulse.
//
// Ports:
//   frame_clk        - frame clock; all state updates on its rising edge
//   Reset            - asynchronous, active-high
//   keycode_0..3     - current HID keycodes
//   RyuX, AkumaX     - fighter X positions (10 bit)
//   AkumaCrouch      - Akuma is blocking
//   XDist            - AkumaX - RyuX, signed, combinational
//   Akuma_Knockback  - signed X displacement for Akuma this frame, registered
//   AkumaHealth      - 0..100, registered
//   RyuAttack        - high while an attack is in progress
//   HitFlash         - one-frame pulse when a hit resolves
//   KO               - set once AkumaHealth reaches 0
//
// Optional feature macro: KNOCKBACK_DECAY_EN
//   defined   - the clean-hit knockback magnitude tapers as max(1, k*KB_SPEED/KB_FRAMES)
//   undefined - the knockback magnitude stays constant for the whole duration
module hit_knockback #(
  parameter logic [7:0] PUNCH_KEY       = 8'h09,
  parameter int         STARTUP_FRAMES  = 4,
  parameter int         ACTIVE_FRAMES   = 3,
  parameter int         RECOVERY_FRAMES = 8,
  parameter int         REACH           = 130,
  parameter int         DAMAGE          = 10,
  parameter int         CHIP            = 1,
  parameter int         KB_FRAMES       = 8,
  parameter int         KB_SPEED        = 3,
  parameter int         BOUND_X_MAX     = 635
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  input  logic [9:0] RyuX,
  input  logic [9:0] AkumaX,
  input  logic       AkumaCrouch,
  output int         XDist,
  output int         Akuma_Knockback,
  output logic [6:0] AkumaHealth,
  output logic       RyuAttack,
  output logic       HitFlash,
  output logic       KO
);

  // Blocked hits play out for half the clean duration, but never for zero frames.
  localparam int KB_BLOCK_FRAMES = (KB_FRAMES / 2 > 0) ? KB_FRAMES / 2 : 1;

  typedef enum logic [2:0] {IDLE, STARTUP, ACTIVE, RECOVERY, KO_LOCK} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       press, press_q, trigger;
  logic       hit_done, hit_window, hit;
  logic [7:0] kb_cnt;
  logic       kb_clean, frame_clean;
  int         dmg, health_after, frame_k, mag, kb_out;

  assign press   = (keycode_0 == PUNCH_KEY) || (keycode_1 == PUNCH_KEY) ||
                   (keycode_2 == PUNCH_KEY) || (keycode_3 == PUNCH_KEY);
  assign trigger = press && !press_q;
  assign XDist   = int'({22'b0, AkumaX}) - int'({22'b0, RyuX});

  always_comb begin
    // Outputs are registered. The hit is therefore resolved on the edges that
    // lead into the ACTIVE frames: the edge leaving STARTUP and every ACTIVE
    // edge except the last. HitFlash and the knockback then appear during
    // the three ACTIVE frames themselves.
    hit_window = ((state == STARTUP) && (cnt == 8'd0)) ||
                 ((state == ACTIVE) && (cnt != 8'd0));
    hit = hit_window && !hit_done && (XDist >= 0) && (XDist <= REACH);

    dmg          = AkumaCrouch ? CHIP : DAMAGE;
    health_after = (int'(AkumaHealth) > dmg) ? int'(AkumaHealth) - dmg : 0;

    // frame_k is the number of knockback frames remaining, counting the
    // current frame. A fresh hit restarts the count at its full length.
    if (hit) begin
      frame_k     = AkumaCrouch ? KB_BLOCK_FRAMES : KB_FRAMES;
      frame_clean = !AkumaCrouch;
    end else begin
      frame_k     = int'(kb_cnt);
      frame_clean = kb_clean;
    end

`ifdef KNOCKBACK_DECAY_EN
    mag = 1;
    if (frame_clean && ((frame_k * KB_SPEED) / KB_FRAMES > 1))
      mag = (frame_k * KB_SPEED) / KB_FRAMES;
`else
    mag = frame_clean ? KB_SPEED : 1;
`endif

    // Akuma's sprite is 125 px wide. Do not push it past the right edge.
    kb_out = 0;
    if ((hit || (kb_cnt != 8'd0)) && (int'({22'b0, AkumaX}) + 125 + mag < BOUND_X_MAX))
      kb_out = mag;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      press_q         <= 1'b0;
      hit_done        <= 1'b0;
      kb_cnt          <= 8'd0;
      kb_clean        <= 1'b0;
      Akuma_Knockback <= 0;
      AkumaHealth     <= 7'd100;
      RyuAttack       <= 1'b0;
      HitFlash        <= 1'b0;
      KO              <= 1'b0;
    end else begin
      press_q         <= press;
      HitFlash        <= hit;
      Akuma_Knockback <= kb_out;

      // kb_cnt holds the frames still to play after the current one.
      if (hit) begin
        kb_cnt      <= 8'(frame_k - 1);
        kb_clean    <= frame_clean;
        hit_done    <= 1'b1;
        AkumaHealth <= 7'(health_after);
      end else if (kb_cnt != 8'd0) begin
        kb_cnt <= kb_cnt - 8'd1;
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= STARTUP;
            cnt       <= 8'(STARTUP_FRAMES - 1);
            hit_done  <= 1'b0;
            RyuAttack <= 1'b1;
          end
        end
        STARTUP: begin
          if (cnt == 8'd0) begin
            state <= ACTIVE;
            cnt   <= 8'(ACTIVE_FRAMES - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACTIVE: begin
          if (cnt == 8'd0) begin
            state <= RECOVERY;
            cnt   <= 8'(RECOVERY_FRAMES - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RECOVERY: begin
          if (cnt == 8'd0) begin
            state     <= IDLE;
            RyuAttack <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        KO_LOCK: begin
          RyuAttack <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          RyuAttack <= 1'b0;
        end
      endcase

      // A lethal hit overrides the attack sequence. KO_LOCK holds until Reset.
      if (hit && (health_after == 0)) begin
        state     <= KO_LOCK;
        KO        <= 1'b1;
        RyuAttack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hit_knockback.sv
// tb_hit_knockback
// Directed testbench for hit_knockback. Each scenario task drives its own
// stimulus and checks the outputs one frame at a time. The frame numbering
// inside a task counts the frames after the edge that sampled the key press
// (frame 1 = first STARTUP frame).
module tb_hit_knockback;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
  logic [9:0] RyuX, AkumaX;
  logic       AkumaCrouch;
  int         XDist, Akuma_Knockback;
  logic [6:0] AkumaHealth;
  logic       RyuAttack, HitFlash, KO;

  int vectors     = 0;
  int miscompares = 0;
  int kb_seq [8];

  always #5 frame_clk = ~frame_clk;

  hit_knockback dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .keycode_0       (keycode_0),
    .keycode_1       (keycode_1),
    .keycode_2       (keycode_2),
    .keycode_3       (keycode_3),
    .RyuX            (RyuX),
    .AkumaX          (AkumaX),
    .AkumaCrouch     (AkumaCrouch),
    .XDist           (XDist),
    .Akuma_Knockback (Akuma_Knockback),
    .AkumaHealth     (AkumaHealth),
    .RyuAttack       (RyuAttack),
    .HitFlash        (HitFlash),
    .KO              (KO)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    keycode_0 = 8'h00; keycode_1 = 8'h00; keycode_2 = 8'h00; keycode_3 = 8'h00;
    step();
    step();
    Reset = 1'b0;
    step();
  endtask

  // Tap the punch key for one frame, then run the remaining frames of the attack.
  task automatic tap_and_run(input int frames);
    keycode_3 = 8'h09;
    step();
    keycode_3 = 8'h00;
    for (int i = 1; i < frames; i++) step();
  endtask

  task automatic test_reset();
    RyuX = 10'd300; AkumaX = 10'd400; AkumaCrouch = 1'b0;
    do_reset();
    vectors++;
    if (Akuma_Knockback !== 0 || AkumaHealth !== 7'd100 || RyuAttack !== 1'b0 ||
        HitFlash !== 1'b0 || KO !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: kb=%0d hp=%0d att=%b flash=%b ko=%b expected kb=0 hp=100 att=0 flash=0 ko=0",
               Akuma_Knockback, AkumaHealth, RyuAttack, HitFlash, KO);
    end
    vectors++;
    if (XDist !== 100) begin
      miscompares++;
      $display("[TB] FAIL xdist_pos: got %0d expected 100", XDist);
    end
    RyuX = 10'd450;
    #1;
    vectors++;
    if (XDist !== -50) begin
      miscompares++;
      $display("[TB] FAIL xdist_neg: got %0d expected -50", XDist);
    end
    RyuX = 10'd300;
  endtask

  task automatic test_clean_hit();
    int exp_kb;
    do_reset();
    RyuX = 10'd300; AkumaX = 10'd400; AkumaCrouch = 1'b0;
    keycode_2 = 8'h09;
    step();
    keycode_2 = 8'h00;
    for (int f = 1; f <= 20; f++) begin
      if (f > 1) step();
      exp_kb = (f >= 5 && f <= 12) ? kb_seq[f-5] : 0;
      vectors++;
      if (RyuAttack !== (f <= 15)) begin
        miscompares++;
        $display("[TB] FAIL clean_attack frame %0d: got %b expected %b", f, RyuAttack, (f <= 15));
      end
      vectors++;
      if (HitFlash !== (f == 5)) begin
        miscompares++;
        $display("[TB] FAIL clean_flash frame %0d: got %b expected %b", f, HitFlash, (f == 5));
      end
      vectors++;
      if (Akuma_Knockback !== exp_kb) begin
        miscompares++;
        $display("[TB] FAIL clean_kb frame %0d: got %0d expected %0d", f, Akuma_Knockback, exp_kb);
      end
      vectors++;
      if (AkumaHealth !== ((f >= 5) ? 7'd90 : 7'd100)) begin
        miscompares++;
        $display("[TB] FAIL clean_health frame %0d: got %0d expected %0d", f, AkumaHealth,
                 (f >= 5) ? 90 : 100);
      end
    end
  endtask

  task automatic test_blocked_hit();
    int exp_kb;
    do_reset();
    RyuX = 10'd300; AkumaX = 10'd400; AkumaCrouch = 1'b1;
    keycode_0 = 8'h09;
    step();
    keycode_0 = 8'h00;
    for (int f = 1; f <= 12; f++) begin
      if (f > 1) step();
      exp_kb = (f >= 5 && f <= 8) ? 1 : 0;
      vectors++;
      if (Akuma_Knockback !== exp_kb) begin
        miscompares++;
        $display("[TB] FAIL block_kb frame %0d: got %0d expected %0d", f, Akuma_Knockback, exp_kb);
      end
      vectors++;
      if (AkumaHealth !== ((f >= 5) ? 7'd99 : 7'd100)) begin
        miscompares++;
        $display("[TB] FAIL block_health frame %0d: got %0d expected %0d", f, AkumaHealth,
                 (f >= 5) ? 99 : 100);
      end
    end
    AkumaCrouch = 1'b0;
  endtask

  task automatic test_reach();
    int ryu_tab   [4] = '{300, 300, 400, 300};
    int akuma_tab [4] = '{431, 430, 300, 300};
    bit hit_tab   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int flashes, kb_frames;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      RyuX = 10'(ryu_tab[t]); AkumaX = 10'(akuma_tab[t]); AkumaCrouch = 1'b0;
      flashes = 0; kb_frames = 0;
      keycode_1 = 8'h09;
      step();
      keycode_1 = 8'h00;
      for (int f = 1; f <= 20; f++) begin
        if (f > 1) step();
        if (HitFlash) flashes++;
        if (Akuma_Knockback != 0) kb_frames++;
      end
      vectors++;
      if (flashes !== (hit_tab[t] ? 1 : 0)) begin
        miscompares++;
        $display("[TB] FAIL reach_flash case %0d: got %0d flashes expected %0d", t, flashes, hit_tab[t]);
      end
      vectors++;
      if (kb_frames !== (hit_tab[t] ? 8 : 0)) begin
        miscompares++;
        $display("[TB] FAIL reach_kb case %0d: got %0d frames expected %0d", t, kb_frames,
                 hit_tab[t] ? 8 : 0);
      end
      vectors++;
      if (AkumaHealth !== (hit_tab[t] ? 7'd90 : 7'd100)) begin
        miscompares++;
        $display("[TB] FAIL reach_health case %0d: got %0d expected %0d", t, AkumaHealth,
                 hit_tab[t] ? 90 : 100);
      end
    end
  endtask

  task automatic test_held_key();
    int att_frames, att_starts, flashes;
    logic prev_att;
    do_reset();
    RyuX = 10'd300; AkumaX = 10'd400; AkumaCrouch = 1'b0;
    att_frames = 0; att_starts = 0; flashes = 0; prev_att = 1'b0;
    keycode_1 = 8'h09;
    for (int f = 1; f <= 40; f++) begin
      step();
      if (RyuAttack) att_frames++;
      if (RyuAttack && !prev_att) att_starts++;
      if (HitFlash) flashes++;
      prev_att = RyuAttack;
    end
    keycode_1 = 8'h00;
    step();
    vectors++;
    if (att_starts !== 1 || att_frames !== 15) begin
      miscompares++;
      $display("[TB] FAIL held_attacks: got %0d starts %0d frames expected 1 starts 15 frames",
               att_starts, att_frames);
    end
    vectors++;
    if (flashes !== 1 || AkumaHealth !== 7'd90) begin
      miscompares++;
      $display("[TB] FAIL held_hits: got %0d flashes hp %0d expected 1 flash hp 90", flashes, AkumaHealth);
    end
  endtask

  task automatic test_bound();
    int ax_tab [2] = '{508, 506};
    int exp_kb, m;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      AkumaX = 10'(ax_tab[t]); RyuX = 10'(ax_tab[t] - 100); AkumaCrouch = 1'b0;
      keycode_0 = 8'h09;
      step();
      keycode_0 = 8'h00;
      for (int f = 1; f <= 14; f++) begin
        if (f > 1) step();
        exp_kb = 0;
        if (f >= 5 && f <= 12) begin
          m = kb_seq[f-5];
          exp_kb = (ax_tab[t] + 125 + m >= 635) ? 0 : m;
        end
        vectors++;
        if (Akuma_Knockback !== exp_kb) begin
          miscompares++;
          $display("[TB] FAIL bound_kb x=%0d frame %0d: got %0d expected %0d", ax_tab[t], f,
                   Akuma_Knockback, exp_kb);
        end
      end
      vectors++;
      if (AkumaHealth !== 7'd90) begin
        miscompares++;
        $display("[TB] FAIL bound_health x=%0d: got %0d expected 90", ax_tab[t], AkumaHealth);
      end
    end
  endtask

  task automatic test_reset_mid_knockback();
    do_reset();
    RyuX = 10'd300; AkumaX = 10'd400; AkumaCrouch = 1'b0;
    tap_and_run(7);
    vectors++;
    if (Akuma_Knockback !== kb_seq[2] || RyuAttack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midkb_pre: got kb=%0d att=%b expected kb=%0d att=1",
               Akuma_Knockback, RyuAttack, kb_seq[2]);
    end
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if (Akuma_Knockback !== 0 || AkumaHealth !== 7'd100 || RyuAttack !== 1'b0 ||
        HitFlash !== 1'b0 || KO !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midkb_reset: kb=%0d hp=%0d att=%b flash=%b ko=%b expected kb=0 hp=100 att=0 flash=0 ko=0",
               Akuma_Knockback, AkumaHealth, RyuAttack, HitFlash, KO);
    end
    Reset = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      step();
      vectors++;
      if (Akuma_Knockback !== 0 || RyuAttack !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midkb_after frame %0d: got kb=%0d att=%b expected kb=0 att=0",
                 f, Akuma_Knockback, RyuAttack);
      end
    end
  endtask

  task automatic test_ko();
    do_reset();
    RyuX = 10'd300; AkumaX = 10'd400;
    AkumaCrouch = 1'b0;
    for (int i = 0; i < 9; i++) tap_and_run(18);
    AkumaCrouch = 1'b1;
    for (int i = 0; i < 5; i++) tap_and_run(18);
    vectors++;
    if (AkumaHealth !== 7'd5 || KO !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ko_setup: got hp=%0d ko=%b expected hp=5 ko=0", AkumaHealth, KO);
    end
    AkumaCrouch = 1'b0;
    tap_and_run(5);
    vectors++;
    if (AkumaHealth !== 7'd0 || KO !== 1'b1 || RyuAttack !== 1'b0 || HitFlash !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ko_hit: got hp=%0d ko=%b att=%b flash=%b expected hp=0 ko=1 att=0 flash=1",
               AkumaHealth, KO, RyuAttack, HitFlash);
    end
    step();
    vectors++;
    if (Akuma_Knockback !== kb_seq[1]) begin
      miscompares++;
      $display("[TB] FAIL ko_kb: got %0d expected %0d", Akuma_Knockback, kb_seq[1]);
    end
    for (int i = 0; i < 10; i++) step();
    keycode_0 = 8'h09;
    step();
    keycode_0 = 8'h00;
    for (int f = 1; f <= 20; f++) begin
      if (f > 1) step();
      vectors++;
      if (RyuAttack !== 1'b0 || KO !== 1'b1 || AkumaHealth !== 7'd0) begin
        miscompares++;
        $display("[TB] FAIL ko_lock frame %0d: got att=%b ko=%b hp=%0d expected att=0 ko=1 hp=0",
                 f, RyuAttack, KO, AkumaHealth);
      end
    end
  endtask

  initial begin
`ifdef KNOCKBACK_DECAY_EN
    kb_seq = '{3, 2, 2, 1, 1, 1, 1, 1};
`else
    kb_seq = '{3, 3, 3, 3, 3, 3, 3, 3};
`endif
    Reset = 1'b1;
    keycode_0 = 8'h00; keycode_1 = 8'h00; keycode_2 = 8'h00; keycode_3 = 8'h00;
    RyuX = 10'd300; AkumaX = 10'd400; AkumaCrouch = 1'b0;
    test_reset();
    test_clean_hit();
    test_blocked_hit();
    test_reach();
    test_held_key();
    test_bound();
    test_reset_mid_knockback();
    test_ko();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
